register_file_mp: RTL and testbench

Parametrised multi-port register file with an integrated write-pending scoreboard. It is the next-generation general-purpose register bank for the Embertrail datapath and is read by the issue stage and written by the writeback stage. It generalises data width, register count and read/write port counts. It adds single-cycle write latency, deterministic write-port priority, collision reporting, per-register busy tracking and an optional write-to-read bypass.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/register_file_mp.sv | 97 +++++++++
 tb/tb_register_file_mp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index/data types for the Embertrail general-purpose register bank.
// Optional write-to-read bypass is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_NUM_RD   = 4;
    localparam int DEFAULT_NUM_WR   = 2;
    localparam int DEFAULT_SP_INDEX = 30;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register plus registered write-conflict pulse.
// Reserve beats a same-cycle write to the same register (the write belongs to the old producer).
module regfile_scoreboard #(
    parameter int  NUM_REGS = regfile_pkg::DEFAULT_NUM_REGS,
    parameter int  NUM_WR   = regfile_pkg::DEFAULT_NUM_WR,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic [NUM_WR-1:0]        write_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] write_sel_i,
    input  logic                     reserve_en_i,
    input  logic [ADDR_W-1:0]        reserve_sel_i,
    output logic [NUM_REGS-1:0]      busy_mask_o,
    output logic                     write_conflict_o
);
    import regfile_pkg::*;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] write_hit;
    logic                conflict_q;
    logic                conflict_d;

    always_comb begin
        write_hit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (write_en_i[w]) begin
                write_hit[write_sel_i[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reserve_en_i && (reserve_sel_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (write_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // Any pair of enabled ports aimed at the same index is a collision.
    always_comb begin
        conflict_d = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (write_en_i[a] && write_en_i[b] &&
                    (write_sel_i[a*ADDR_W +: ADDR_W] == write_sel_i[b*ADDR_W +: ADDR_W])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy_mask_o      = busy_q;
    assign write_conflict_o = conflict_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with single-cycle writes, highest-port-wins write priority and busy tracking.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file_mp #(
    parameter int                DATA_W   = regfile_pkg::DEFAULT_DATA_W,
    parameter int                NUM_REGS = regfile_pkg::DEFAULT_NUM_REGS,
    parameter int                NUM_RD   = regfile_pkg::DEFAULT_NUM_RD,
    parameter int                NUM_WR   = regfile_pkg::DEFAULT_NUM_WR,
    parameter int                SP_INDEX = regfile_pkg::DEFAULT_SP_INDEX,
    parameter logic [DATA_W-1:0] SP_RESET = '0,
    localparam int               ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic [NUM_RD-1:0]        iReadEn,
    input  logic [NUM_RD*ADDR_W-1:0] iReadSel,
    output logic [NUM_RD*DATA_W-1:0] oReadData,
    output logic [NUM_RD-1:0]        oReadBusy,
    input  logic [NUM_WR-1:0]        iWriteEn,
    input  logic [NUM_WR*ADDR_W-1:0] iWriteSel,
    input  logic [NUM_WR*DATA_W-1:0] iWriteData,
    input  logic                     iReserveEn,
    input  logic [ADDR_W-1:0]        iReserveSel,
    output logic [NUM_REGS-1:0]      oBusyMask,
    output logic                     oWriteConflict,
    output logic [DATA_W-1:0]        oStackPointer
);
    import regfile_pkg::*;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_mask;
    logic [ADDR_W-1:0]   rd_sel [NUM_RD];

    // Ports are applied in ascending order so the highest-numbered enabled port wins.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (iWriteEn[w]) begin
                regs_d[iWriteSel[w*ADDR_W +: ADDR_W]] = iWriteData[w*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= (r == SP_INDEX) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .iClock           (iClock),
        .iReset           (iReset),
        .write_en_i       (iWriteEn),
        .write_sel_i      (iWriteSel),
        .reserve_en_i     (iReserveEn),
        .reserve_sel_i    (iReserveSel),
        .busy_mask_o      (busy_mask),
        .write_conflict_o (oWriteConflict)
    );

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_sel[p] = iReadSel[p*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        oReadData = '0;
        oReadBusy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (iReadEn[p]) begin
                oReadData[p*DATA_W +: DATA_W] = regs_q[rd_sel[p]];
                oReadBusy[p]                  = busy_mask[rd_sel[p]];
`ifdef REGFILE_BYPASS_EN
                // A forwarded value has no pending producer unless a new one reserves it right now.
                for (int w = 0; w < NUM_WR; w++) begin
                    if (iWriteEn[w] && (iWriteSel[w*ADDR_W +: ADDR_W] == rd_sel[p])) begin
                        oReadData[p*DATA_W +: DATA_W] = iWriteData[w*DATA_W +: DATA_W];
                        oReadBusy[p]                  = iReserveEn && (iReserveSel == rd_sel[p]);
                    end
                end
`endif
            end
        end
    end

    assign oBusyMask     = busy_mask;
    assign oStackPointer = regs_q[SP_INDEX];

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp (default geometry, SP_RESET = 16'h0F00).
// Expectations for the bypass build are selected with REGFILE_BYPASS_EN.
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int DW  = 16;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 4;
  localparam int NWR = 2;

  logic             clk;
  logic             rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_sel;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_sel;
  logic [NWR*DW-1:0] wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_sel;
  logic [NR-1:0]     busy_mask;
  logic              wr_conflict;
  logic [DW-1:0]     stack_ptr;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  register_file_mp #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR),
    .SP_INDEX (30),
    .SP_RESET (16'h0F00)
  ) dut (
    .iClock         (clk),
    .iReset         (rst),
    .iReadEn        (rd_en),
    .iReadSel       (rd_sel),
    .oReadData      (rd_data),
    .oReadBusy      (rd_busy),
    .iWriteEn       (wr_en),
    .iWriteSel      (wr_sel),
    .iWriteData     (wr_data),
    .iReserveEn     (rsv_en),
    .iReserveSel    (rsv_sel),
    .oBusyMask      (busy_mask),
    .oWriteConflict (wr_conflict),
    .oStackPointer  (stack_ptr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive_idle();
    rd_en   = '0;
    rd_sel  = '0;
    wr_en   = '0;
    wr_sel  = '0;
    wr_data = '0;
    rsv_en  = 1'b0;
    rsv_sel = '0;
  endtask

  task automatic set_read(input int p, input reg_idx_t sel);
    rd_en[p]          = 1'b1;
    rd_sel[p*AW +: AW] = sel;
  endtask

  task automatic set_write(input int w, input reg_idx_t sel, input reg_data_t data);
    wr_en[w]            = 1'b1;
    wr_sel[w*AW +: AW]  = sel;
    wr_data[w*DW +: DW] = data;
  endtask

  task automatic set_reserve(input reg_idx_t sel);
    rsv_en  = 1'b1;
    rsv_sel = sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    settle();

    // reset contents: everything zero except the stack pointer register
    for (int i = 0; i < NR; i++) exp_q.push_back((i == 30) ? 16'h0F00 : 16'h0000);
    for (int i = 0; i < NR; i++) begin
      drive_idle();
      set_read(i % NRD, reg_idx_t'(i));
      settle();
      check($sformatf("reset_r%0d", i), 32'(port_data(i % NRD)), 32'(exp_q.pop_front()));
    end
    check("reset_sp", 32'(stack_ptr), 32'h0F00);
    check("reset_busy_mask", 32'(busy_mask), 32'h0);
    check("reset_conflict", 32'(wr_conflict), 32'h0);

    // single write, read on port 2 during and after the write edge
    drive_idle();
    set_write(0, 5'd5, 16'hA5A5);
    set_read(2, 5'd5);
    rd_sel[1*AW +: AW] = 5'd5;
    settle();
`ifdef REGFILE_BYPASS_EN
    check("wr_r5_same_cycle", 32'(port_data(2)), 32'hA5A5);
`else
    check("wr_r5_same_cycle", 32'(port_data(2)), 32'h0000);
`endif
    check("disabled_port_data", 32'(port_data(1)), 32'h0);
    step();
    wr_en = '0;
    settle();
    check("wr_r5_next_cycle", 32'(port_data(2)), 32'hA5A5);
    check("wr_r5_busy", 32'(rd_busy[2]), 32'h0);

    // colliding writes to r7: port 1 wins and conflict pulses once
    drive_idle();
    set_write(0, 5'd7, 16'h1111);
    set_write(1, 5'd7, 16'h2222);
    settle();
    check("conflict_before_edge", 32'(wr_conflict), 32'h0);
    step();
    drive_idle();
    set_read(0, 5'd7);
    settle();
    check("r7_priority", 32'(port_data(0)), 32'h2222);
    check("conflict_pulse", 32'(wr_conflict), 32'h1);
    step();
    check("conflict_drop", 32'(wr_conflict), 32'h0);

    // distinct dual write: no conflict, both land
    drive_idle();
    set_write(0, 5'd10, 16'h1234);
    set_write(1, 5'd11, 16'h5678);
    step();
    drive_idle();
    set_read(0, 5'd10);
    set_read(3, 5'd11);
    settle();
    check("dual_r10", 32'(port_data(0)), 32'h1234);
    check("dual_r11", 32'(port_data(3)), 32'h5678);
    check("dual_no_conflict", 32'(wr_conflict), 32'h0);

    // reserve r3, then write it two edges later
    drive_idle();
    set_reserve(5'd3);
    step();
    drive_idle();
    set_read(0, 5'd3);
    rd_sel[1*AW +: AW] = 5'd3;
    settle();
    check("rsv_r3_mask_c1", 32'(busy_mask[3]), 32'h1);
    check("rsv_r3_busy_c1", 32'(rd_busy[0]), 32'h1);
    check("rsv_r3_disabled_busy", 32'(rd_busy[1]), 32'h0);
    step();
    set_write(0, 5'd3, 16'h0033);
    settle();
    check("rsv_r3_mask_c2", 32'(busy_mask[3]), 32'h1);
`ifdef REGFILE_BYPASS_EN
    check("rsv_r3_busy_c2", 32'(rd_busy[0]), 32'h0);
`else
    check("rsv_r3_busy_c2", 32'(rd_busy[0]), 32'h1);
`endif
    step();
    wr_en = '0;
    settle();
    check("rsv_r3_mask_c3", 32'(busy_mask[3]), 32'h0);
    check("rsv_r3_busy_c3", 32'(rd_busy[0]), 32'h0);
    check("rsv_r3_data", 32'(port_data(0)), 32'h0033);

    // reserve and write r9 together: reserve wins, data still lands
    drive_idle();
    set_reserve(5'd9);
    set_write(1, 5'd9, 16'h0099);
    step();
    drive_idle();
    set_read(2, 5'd9);
    settle();
    check("rsv_wr_r9_mask", 32'(busy_mask[9]), 32'h1);
    check("rsv_wr_r9_data", 32'(port_data(2)), 32'h0099);
    set_reserve(5'd9);
    step();
    rsv_en = 1'b0;
    settle();
    check("rsv_r9_again", 32'(busy_mask), 32'h0000_0200);

    // pre-load r1 and r30 so the reset test has something to clear
    drive_idle();
    set_write(0, 5'd1, 16'h5555);
    set_write(1, 5'd30, 16'hBEEF);
    step();
    drive_idle();
    set_read(0, 5'd1);
    settle();
    check("r1_preload", 32'(port_data(0)), 32'h5555);
    check("sp_written", 32'(stack_ptr), 32'hBEEF);

    // reset overrides writes and reserve in the same cycle
    drive_idle();
    rst = 1'b1;
    set_write(0, 5'd1, 16'hFFFF);
    set_write(1, 5'd1, 16'hFFFF);
    set_reserve(5'd1);
    step();
    rst = 1'b0;
    drive_idle();
    set_read(0, 5'd1);
    settle();
    check("rst_r1_data", 32'(port_data(0)), 32'h0);
    check("rst_r1_busy", 32'(busy_mask[1]), 32'h0);
    check("rst_busy_mask", 32'(busy_mask), 32'h0);
    check("rst_conflict", 32'(wr_conflict), 32'h0);
    check("rst_sp", 32'(stack_ptr), 32'h0F00);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
